seg_display: RTL and testbench
==============================

SEG_DISPLAY -- requirements
Module: seg_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit is driven (minimum 1).
REQ-002 SHALL have parameter DB_CYCLES, default 1000000, consecutive stable synchronized cycles required to accept a mode_btn level change (minimum 1).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port value_in  input  32  syscall print value from the CPU.
REQ-006 SHALL have port pc_in  input  15  CPU program counter bits [14:0].
REQ-007 SHALL have port mode_btn  input  1  raw, asynchronous, bouncing push-button.
REQ-008 SHALL have port seg  output  8  active-low segments: seg[0..6]=a..g, seg[7]=dp.
REQ-009 SHALL have port an  output  8  active-low digit enables, one-hot; an[i] = hex digit i (i=0 least significant).
REQ-010 SHALL have port mode  output  1  registered source select: 0 = value_in, 1 = pc_in.

Function
REQ-011 SHALL pass mode_btn through a 2-flop synchronizer before any other use.
REQ-012 Debouncer SHALL count cycles in which the synchronized level differs from the debounced level; a matching cycle clears the count; the debounced level SHALL adopt the synchronized level when the count reaches DB_CYCLES.
REQ-013 Each debounced 0->1 transition SHALL toggle mode exactly once; holding the button SHALL NOT re-toggle; bounces shorter than DB_CYCLES SHALL be ignored.
REQ-014 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; the terminal count is the scan tick.
REQ-015 On each scan tick, digit index SHALL advance modulo 8 (7 wraps to 0).
REQ-016 Frame boundary = scan tick with index 7; on it, disp_word SHALL load mode ? {17'b0, pc_in} : value_in and disp_mode SHALL load mode.
REQ-017 disp_word SHALL NOT change between frame boundaries; input or mode changes mid-frame take effect at the next boundary (no tearing).
REQ-018 an and seg SHALL be registered and update on the same edge as the index, already reflecting the new index and any newly loaded disp_word.
REQ-019 seg[6:0] SHALL be the active-low hex glyph (0-F) of nibble disp_word[4i+3:4i] for active digit i.
REQ-020 seg[7] SHALL be 0 (dp lit) only on digit 0 when disp_mode=1; otherwise 1.
REQ-021 SCAN_DIV=1 SHALL advance the index every cycle with no lost digits.
REQ-022 Simultaneous mode toggle and frame boundary: disp_word SHALL load using the pre-toggle mode; the new mode applies from the next frame.

Reset
REQ-023 While rst_n=0: prescaler=0, index=0, debounce count=0, debounced level=0, synchronizer=0, mode=0, disp_mode=0, disp_word=0, an=8'hFE, seg=8'hC0.
REQ-024 Reset assertion mid-frame SHALL force all REQ-023 values immediately, without waiting for clk; scanning restarts at digit 0 on the first edge after release.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN defined: a digit i>0 whose nibble and all higher nibbles of disp_word are zero SHALL output seg=8'hFF (an still cycles); digit 0 is never blanked.
REQ-026 Macro LEADING_ZERO_BLANK_EN undefined: all eight digits SHALL always show their glyph; no blanking logic is present.

Verification (SCAN_DIV=4, DB_CYCLES=8)
REQ-027 Reset held then released -> an=8'hFE, seg=8'hC0, mode=0; an becomes 8'hFD after 4 clocks.
REQ-028 value_in=32'h1234ABCD held over two frames (64 clocks) -> second frame: digit 0 seg=8'hA1 ('D'), digit 7 seg=8'hF9 ('1'), dp off throughout.
REQ-029 mode_btn high 5 cycles then low -> mode stays 0; high for 12 cycles -> mode=1 exactly 2+8 edges after rising, one toggle; next frame shows pc_in=15'h0040 as 00000040 with digit 0 seg=8'h40 (dp lit).
REQ-030 value_in changed from 32'h11111111 to 32'h22222222 at digit 3 -> digits 4..7 still show '1' (8'hF9) until the frame boundary, then '2' (8'hA4).
REQ-031 value_in=32'h0000002A: macro defined -> digits 2..7 seg=8'hFF, digit 1 8'hA4, digit 0 8'h88; macro undefined -> digits 2..7 seg=8'hC0.
REQ-032 rst_n pulsed low at digit 5 mid-count -> an=8'hFE, seg=8'hC0, mode=0 before the next clk edge.

Source files
------------

// File: rtl/seg_display.sv
// Eight-digit multiplexed hex display with a debounced mode button selecting value_in or pc_in.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module seg_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value_in,
    input  logic [14:0] pc_in,
    input  logic        mode_btn,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic        mode
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DB_CYCLES + 1);

    logic [1:0]    sync_ff;
    logic          btn_sync;
    logic [DW-1:0] db_cnt;
    logic          db_level;
    logic          rise;

    logic [PW-1:0] presc;
    logic          tick;
    logic [2:0]    idx;
    logic          frame;
    logic [31:0]   disp_word;
    logic          disp_mode;

    logic [2:0]    next_idx;
    logic [31:0]   next_word;
    logic          next_dmode;
    logic [3:0]    nibble;
    logic          blank;
    logic [7:0]    next_an;
    logic [7:0]    next_seg;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    assign btn_sync = sync_ff[1];
    // The toggle fires on the same edge the debounced level rises.
    assign rise  = btn_sync && !db_level && (db_cnt == DW'(DB_CYCLES - 1));
    assign tick  = (presc == PW'(SCAN_DIV - 1));
    assign frame = tick && (idx == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff  <= 2'b00;
            db_cnt   <= '0;
            db_level <= 1'b0;
            mode     <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], mode_btn};
            if (btn_sync == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DB_CYCLES - 1)) begin
                db_cnt   <= '0;
                db_level <= btn_sync;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
            if (rise) begin
                mode <= ~mode;
            end
        end
    end

    // Outputs are computed from the post-edge index and word so they change together.
    always_comb begin
        next_idx   = idx + 3'd1;
        next_word  = disp_word;
        next_dmode = disp_mode;
        if (frame) begin
            next_word  = mode ? {17'b0, pc_in} : value_in;
            next_dmode = mode;
        end
        nibble = next_word[{next_idx, 2'b00} +: 4];
        blank  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if ((next_idx != 3'd0) && ((next_word >> {next_idx, 2'b00}) == 32'd0)) begin
            blank = 1'b1;
        end
`endif
        next_an  = ~(8'b1 << next_idx);
        next_seg = {~((next_idx == 3'd0) && next_dmode), glyph(nibble)};
        if (blank) begin
            next_seg = 8'hFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            idx       <= 3'd0;
            disp_word <= 32'd0;
            disp_mode <= 1'b0;
            an        <= 8'hFE;
            seg       <= 8'hC0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                idx       <= next_idx;
                disp_word <= next_word;
                disp_mode <= next_dmode;
                an        <= next_an;
                seg       <= next_seg;
            end
        end
    end

endmodule

// File: tb/tb_seg_display.sv
// Directed self-checking bench for seg_display with SCAN_DIV=4, DB_CYCLES=8.
module tb_seg_display;

    logic        clk;
    logic        rst_n;
    logic [31:0] value_in;
    logic [14:0] pc_in;
    logic        mode_btn;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        mode;

    int compared   = 0;
    int mismatched = 0;

    seg_display #(.SCAN_DIV(4), .DB_CYCLES(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value_in (value_in),
        .pc_in    (pc_in),
        .mode_btn (mode_btn),
        .seg      (seg),
        .an       (an),
        .mode     (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the first negedge showing digit 0 right after a frame load.
    task automatic sync_frame();
        bit seen7 = 1'b0;
        bit found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (an == 8'hFE && seen7) found = 1'b1;
            seen7 = (an == 8'h7F);
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("[TB] FAIL sync_frame: frame boundary not seen within 200 cycles, an=%h", an);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        compared++;
        if (an !== 8'hFE) begin mismatched++; $display("[TB] FAIL reset_an: got %h want fe", an); end
        compared++;
        if (seg !== 8'hC0) begin mismatched++; $display("[TB] FAIL reset_seg: got %h want c0", seg); end
        compared++;
        if (mode !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mode: got %b want 0", mode); end
        rst_n = 1'b1;
        step(3);
        compared++;
        if (an !== 8'hFE) begin mismatched++; $display("[TB] FAIL an_after_3: got %h want fe", an); end
        step(1);
        compared++;
        if (an !== 8'hFD) begin mismatched++; $display("[TB] FAIL an_after_4: got %h want fd", an); end
    endtask

    task automatic test_value();
        logic [7:0] exp [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        value_in = 32'h1234ABCD;
        sync_frame();
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (seg !== exp[i] || an !== ~(8'b1 << i)) begin
                mismatched++;
                $display("[TB] FAIL value_digit%0d: got seg=%h an=%h want seg=%h an=%h",
                         i, seg, an, exp[i], ~(8'b1 << i));
            end
            step(4);
        end
    endtask

    task automatic test_debounce();
        mode_btn = 1'b1;
        step(5);
        mode_btn = 1'b0;
        step(20);
        compared++;
        if (mode !== 1'b0) begin mismatched++; $display("[TB] FAIL short_press: got %b want 0", mode); end
        pc_in    = 15'h0040;
        mode_btn = 1'b1;
        step(9);
        compared++;
        if (mode !== 1'b0) begin mismatched++; $display("[TB] FAIL press_edge9: got %b want 0", mode); end
        step(1);
        compared++;
        if (mode !== 1'b1) begin mismatched++; $display("[TB] FAIL press_edge10: got %b want 1", mode); end
        step(2);
        mode_btn = 1'b0;
        step(20);
        compared++;
        if (mode !== 1'b1) begin mismatched++; $display("[TB] FAIL single_toggle: got %b want 1", mode); end
        sync_frame();
        compared++;
        if (seg !== 8'h40) begin mismatched++; $display("[TB] FAIL pc_digit0: got %h want 40", seg); end
        step(4);
        compared++;
        if (seg !== 8'h99) begin mismatched++; $display("[TB] FAIL pc_digit1: got %h want 99", seg); end
        step(4);
        compared++;
`ifdef LEADING_ZERO_BLANK_EN
        if (seg !== 8'hFF) begin mismatched++; $display("[TB] FAIL pc_digit2: got %h want ff", seg); end
`else
        if (seg !== 8'hC0) begin mismatched++; $display("[TB] FAIL pc_digit2: got %h want c0", seg); end
`endif
    endtask

    task automatic test_async_reset();
        sync_frame();
        step(22);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (an !== 8'hFE || seg !== 8'hC0 || mode !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got an=%h seg=%h mode=%b want fe c0 0", an, seg, mode);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(4);
        compared++;
        if (an !== 8'hFD) begin mismatched++; $display("[TB] FAIL restart_scan: got %h want fd", an); end
    endtask

    task automatic test_no_tearing();
        value_in = 32'h11111111;
        sync_frame();
        step(12);
        value_in = 32'h22222222;
        for (int i = 4; i < 8; i++) begin
            step(4);
            compared++;
            if (seg !== 8'hF9) begin mismatched++; $display("[TB] FAIL tear_digit%0d: got %h want f9", i, seg); end
        end
        for (int i = 0; i < 3; i++) begin
            step(4);
            compared++;
            if (seg !== 8'hA4) begin mismatched++; $display("[TB] FAIL new_digit%0d: got %h want a4", i, seg); end
        end
    endtask

    task automatic test_blank();
        logic [7:0] hi;
`ifdef LEADING_ZERO_BLANK_EN
        hi = 8'hFF;
`else
        hi = 8'hC0;
`endif
        value_in = 32'h0000002A;
        sync_frame();
        compared++;
        if (seg !== 8'h88) begin mismatched++; $display("[TB] FAIL blank_digit0: got %h want 88", seg); end
        step(4);
        compared++;
        if (seg !== 8'hA4) begin mismatched++; $display("[TB] FAIL blank_digit1: got %h want a4", seg); end
        for (int i = 2; i < 8; i++) begin
            step(4);
            compared++;
            if (seg !== hi) begin mismatched++; $display("[TB] FAIL blank_digit%0d: got %h want %h", i, seg, hi); end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        value_in = 32'd0;
        pc_in    = 15'd0;
        mode_btn = 1'b0;
        test_reset();
        test_value();
        test_debounce();
        test_async_reset();
        test_no_tearing();
        test_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
